// File: rtl/px_grey_pack.sv
// RGB565/grey8 to 8-bit luma converter that packs pixels into BRAM words for a row-window ring.
// It also tracks ring occupancy in pixels so that AXI bursts are only requested when space is guaranteed.
module px_grey_pack #(
  parameter int unsigned IMG_W       = 640,
  parameter int unsigned IMG_H       = 480,
  parameter int unsigned WND_ROWS    = 8,
  parameter int unsigned PX_PER_WORD = 2,
  parameter int unsigned BURST_LEN   = 128,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] px_data,
  input  logic        px_valid,
  input  logic        fmt_grey,
  input  logic        row_ack,
  output logic        ready_to_rd,
  output logic [11:0] mst_length,
  output logic [3:0]  bram_we,
  output logic        bram_wr_en,
  output logic [31:0] bram_addr,
  output logic [31:0] bram_data,
  output logic        wnd_in_bram,
  output logic        frame_done,
  output logic        err_ovf,
  output logic        err_unf,
  output logic        busy
);

  localparam int unsigned FULL     = WND_ROWS * IMG_W;
  localparam int unsigned DEPTH    = FULL / PX_PER_WORD;
  localparam int unsigned HEADROOM = 2 * BURST_LEN;
  localparam int unsigned OCC_W    = $clog2(FULL + 1);
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned LANE_W   = (PX_PER_WORD > 1) ? $clog2(PX_PER_WORD) : 1;

  // S1
  logic             s1_vld_q, s1_vld_d, s1_fmt_q, s1_fmt_d, s1_last_q, s1_last_d;
  logic [15:0]      s1_data_q, s1_data_d;
  // S2
  logic             s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
  logic [7:0]       s2_y_q, s2_y_d;
  // S3 / write port
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]      pack_q, pack_d, data_q, data_d, addr_q, addr_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             wr_en_q, wr_en_d, fdone_q, fdone_d;
  // occupancy, counters, flags
  logic [OCC_W-1:0] occ_q, occ_d, res_q, res_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             ready_q, ready_d, wnd_q, wnd_d, ovf_q, ovf_d, unf_q, unf_d;

  // combinational temporaries
  logic             ack_hon, accept;
  logic [7:0]       r8, g8, b8;
  logic [15:0]      y_sum;
  logic [31:0]      word_nxt;
  logic [OCC_W-1:0] res_sum;

  // Next-state logic for every stage and counter
  always_comb begin
    ack_hon   = row_ack && (occ_q >= OCC_W'(IMG_W));
    accept    = px_valid && ((occ_q < OCC_W'(FULL)) || ack_hon);

    occ_d     = occ_q;
    if (accept)  occ_d = occ_d + OCC_W'(1);
    if (ack_hon) occ_d = occ_d - OCC_W'(IMG_W);
    ovf_d     = ovf_q | (px_valid & ~accept);
    unf_d     = unf_q | (row_ack & ~ack_hon);
    ready_d   = (32'(FULL) - 32'(occ_q)) >= 32'(HEADROOM);

    col_d     = col_q;
    row_d     = row_q;
    if (accept) begin
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    s1_vld_d  = accept;
    s1_data_d = accept ? px_data : s1_data_q;
    s1_fmt_d  = accept ? fmt_grey : s1_fmt_q;
    s1_last_d = accept && (col_q == COL_W'(IMG_W - 1)) && (row_q == ROW_W'(IMG_H - 1));

    // BT.601 luma with 5/6-bit channels widened by MSB replication
    r8        = {s1_data_q[15:11], s1_data_q[15:13]};
    g8        = {s1_data_q[10:5],  s1_data_q[10:9]};
    b8        = {s1_data_q[4:0],   s1_data_q[4:2]};
    y_sum     = 16'(r8) * 16'd77 + 16'(g8) * 16'd150 + 16'(b8) * 16'd29;
    s2_vld_d  = s1_vld_q;
    s2_last_d = s1_vld_q & s1_last_q;
    s2_y_d    = s1_vld_q ? (s1_fmt_q ? s1_data_q[7:0] : 8'(y_sum >> 8)) : s2_y_q;

    word_nxt  = pack_q;
    word_nxt[{lane_q, 3'b000} +: 8] = s2_y_q;
    pack_d    = pack_q;
    lane_d    = lane_q;
    wr_en_d   = 1'b0;
    fdone_d   = 1'b0;
    data_d    = data_q;
    addr_d    = addr_q;
    ptr_d     = ptr_q;
    if (s2_vld_q) begin
      if (lane_q == LANE_W'(PX_PER_WORD - 1)) begin
        wr_en_d = 1'b1;
        fdone_d = s2_last_q;
        data_d  = word_nxt;
        addr_d  = ADDR_BASE + 32'(ptr_q);
        ptr_d   = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        lane_d  = '0;
        pack_d  = '0;
      end else begin
        pack_d  = word_nxt;
        lane_d  = lane_q + LANE_W'(1);
      end
    end

    // Pixels actually resident in BRAM; clamps if a row is released before its words land
    res_sum   = res_q + (wr_en_q ? OCC_W'(PX_PER_WORD) : OCC_W'(0));
    res_d     = res_sum;
    if (ack_hon) res_d = (res_sum >= OCC_W'(IMG_W)) ? res_sum - OCC_W'(IMG_W) : '0;
    wnd_d     = res_d >= OCC_W'(FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_fmt_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_data_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_last_q <= 1'b0;
      s2_y_q    <= '0;
      lane_q    <= '0;
      pack_q    <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      fdone_q   <= 1'b0;
      occ_q     <= '0;
      res_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      ready_q   <= 1'b0;
      wnd_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_fmt_q  <= s1_fmt_d;
      s1_last_q <= s1_last_d;
      s1_data_q <= s1_data_d;
      s2_vld_q  <= s2_vld_d;
      s2_last_q <= s2_last_d;
      s2_y_q    <= s2_y_d;
      lane_q    <= lane_d;
      pack_q    <= pack_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      fdone_q   <= fdone_d;
      occ_q     <= occ_d;
      res_q     <= res_d;
      col_q     <= col_d;
      row_q     <= row_d;
      ready_q   <= ready_d;
      wnd_q     <= wnd_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign ready_to_rd = ready_q;
  assign mst_length  = 12'(BURST_LEN);
  assign bram_we     = wr_en_q ? 4'hF : 4'h0;
  assign bram_wr_en  = wr_en_q;
  assign bram_addr   = addr_q;
  assign bram_data   = data_q;
  assign wnd_in_bram = wnd_q;
  assign frame_done  = fdone_q;
  assign err_ovf     = ovf_q;
  assign err_unf     = unf_q;
  assign busy        = s1_vld_q | s2_vld_q | (lane_q != '0);

endmodule

// File: tb/tb_px_grey_pack.sv
// Directed bench for px_grey_pack: the frame height is shortened to 16 rows so that a full frame
// fits in a short run, while the ring geometry stays 640 x 8 rows with 2 pixels per word.
module tb_px_grey_pack;

  localparam int unsigned IMG_W = 640;
  localparam int unsigned IMG_H = 16;
  localparam int unsigned NPIX  = IMG_W * IMG_H;

  localparam logic [15:0] LUMA_PX  [6] = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0, 16'hAB5A, 16'h001F};
  localparam logic        LUMA_FMT [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic        LUMA_WE  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [31:0] LUMA_WD  [3] = '{32'h0000_00FF, 32'h0000_954C, 32'h0000_1C5A};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] px_data = '0;
  logic        px_valid = 1'b0, fmt_grey = 1'b0, row_ack = 1'b0;
  logic        ready_to_rd, bram_wr_en, wnd_in_bram, frame_done, err_ovf, err_unf, busy;
  logic [11:0] mst_length;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr, bram_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  px_grey_pack #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WND_ROWS(8), .PX_PER_WORD(2),
                 .BURST_LEN(128), .ADDR_BASE(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .px_data(px_data), .px_valid(px_valid), .fmt_grey(fmt_grey),
    .row_ack(row_ack), .ready_to_rd(ready_to_rd), .mst_length(mst_length), .bram_we(bram_we),
    .bram_wr_en(bram_wr_en), .bram_addr(bram_addr), .bram_data(bram_data),
    .wnd_in_bram(wnd_in_bram), .frame_done(frame_done), .err_ovf(err_ovf), .err_unf(err_unf),
    .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    px_valid = 1'b0; row_ack = 1'b0; fmt_grey = 1'b0; px_data = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic stream_grey(input int n);
    for (int j = 0; j < n; j++) begin
      px_valid = 1'b1; fmt_grey = 1'b1; px_data = 16'(j & 255);
      step();
    end
    idle_in();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; px_valid = 1'b1; px_data = 16'hFFFF;
    repeat (2) step();
    n_checks++; if (ready_to_rd !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready_to_rd); end
    n_checks++; if (mst_length !== 12'd128) begin n_fail++; $display("FAIL reset_len: got %0d want 128", mst_length); end
    n_checks++; if (bram_wr_en !== 1'b0 || bram_we !== 4'h0) begin n_fail++; $display("FAIL reset_we: got %b/%h want 0/0", bram_wr_en, bram_we); end
    n_checks++; if (bram_addr !== 32'h0 || bram_data !== 32'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", bram_addr, bram_data); end
    n_checks++; if ({wnd_in_bram, frame_done, err_ovf, err_unf, busy} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {wnd_in_bram, frame_done, err_ovf, err_unf, busy}); end
    px_valid = 1'b0; px_data = '0; rst_n = 1'b1;
    step();
    n_checks++; if (ready_to_rd !== 1'b1) begin n_fail++; $display("FAIL reset_ready_release: got %b want 1", ready_to_rd); end
  endtask

  task automatic test_luma();
    int w = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++; if (bram_wr_en !== LUMA_WE[i]) begin n_fail++; $display("FAIL luma_wr_en[%0d]: got %b want %b", i, bram_wr_en, LUMA_WE[i]); end
      if (LUMA_WE[i]) begin
        n_checks++; if (bram_addr !== 32'(w) || bram_data !== LUMA_WD[w] || bram_we !== 4'hF) begin
          n_fail++; $display("FAIL luma_word%0d: got addr %0d data %h we %h want addr %0d data %h we f", w, bram_addr, bram_data, bram_we, w, LUMA_WD[w]);
        end
        w++;
      end
      if (i == 1) begin
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL luma_busy: got %b want 1", busy); end
      end
      if (i < 6) begin px_valid = 1'b1; px_data = LUMA_PX[i]; fmt_grey = LUMA_FMT[i]; end
      else idle_in();
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL luma_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_fill();
    int first_nr = -1, first_wnd = -1, nwr = 0;
    logic [31:0] last_addr = '0, last_data = '0;
    do_reset();
    for (int i = 0; i < 5130; i++) begin
      step();
      if (ready_to_rd === 1'b0 && first_nr < 0) first_nr = i;
      if (wnd_in_bram === 1'b1 && first_wnd < 0) first_wnd = i;
      if (bram_wr_en === 1'b1) begin
        nwr++;
        if (i == 5122) begin last_addr = bram_addr; last_data = bram_data; end
      end
      if (i < 5120) begin px_valid = 1'b1; fmt_grey = 1'b1; px_data = 16'(i & 255); end
      else idle_in();
    end
    // ready reflects occupancy of the previous edge: first low when 4865 pixels are resident
    n_checks++; if (first_nr != 4866) begin n_fail++; $display("FAIL fill_ready_fall: got cycle %0d want 4866", first_nr); end
    n_checks++; if (first_wnd != 5123) begin n_fail++; $display("FAIL fill_wnd_rise: got cycle %0d want 5123", first_wnd); end
    n_checks++; if (nwr != 2560) begin n_fail++; $display("FAIL fill_writes: got %0d want 2560", nwr); end
    n_checks++; if (last_addr !== 32'd2559 || last_data !== 32'h0000_FFFE) begin n_fail++; $display("FAIL fill_last_word: got %0d/%h want 2559/0000fffe", last_addr, last_data); end
    n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf: got %b want 0", err_ovf); end
    px_valid = 1'b1; fmt_grey = 1'b1; px_data = 16'h0077;
    step();
    idle_in();
    n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL fill_ovf: got %b want 1", err_ovf); end
    nwr = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bram_wr_en === 1'b1 || busy === 1'b1) nwr++;
    end
    n_checks++; if (nwr != 0) begin n_fail++; $display("FAIL fill_drop_no_write: got %0d active cycles want 0", nwr); end
  endtask

  task automatic test_wrap();
    int nwr = 0;
    step();
    row_ack = 1'b1;
    step();
    row_ack = 1'b0;
    n_checks++; if (wnd_in_bram !== 1'b0) begin n_fail++; $display("FAIL wrap_wnd_fall: got %b want 0", wnd_in_bram); end
    n_checks++; if (err_ovf !== 1'b1 || err_unf !== 1'b0) begin n_fail++; $display("FAIL wrap_sticky: got ovf %b unf %b want 1 0", err_ovf, err_unf); end
    px_valid = 1'b1; fmt_grey = 1'b1; px_data = 16'h0011;
    step();
    n_checks++; if (ready_to_rd !== 1'b1) begin n_fail++; $display("FAIL wrap_ready: got %b want 1", ready_to_rd); end
    px_data = 16'h0022;
    step();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      step();
      if (bram_wr_en === 1'b1) begin
        nwr++;
        n_checks++; if (bram_addr !== 32'd0 || bram_data !== 32'h0000_2211) begin n_fail++; $display("FAIL wrap_word: got %0d/%h want 0/00002211", bram_addr, bram_data); end
      end
    end
    n_checks++; if (nwr != 1) begin n_fail++; $display("FAIL wrap_count: got %0d want 1", nwr); end
  endtask

  task automatic test_simul();
    do_reset();
    stream_grey(5120);
    repeat (3) step();
    n_checks++; if (ready_to_rd !== 1'b0 || err_ovf !== 1'b0) begin n_fail++; $display("FAIL simul_full: got ready %b ovf %b want 0 0", ready_to_rd, err_ovf); end
    px_valid = 1'b1; row_ack = 1'b1; fmt_grey = 1'b1; px_data = 16'h0033;
    step();
    idle_in();
    n_checks++; if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin n_fail++; $display("FAIL simul_accept: got ovf %b unf %b want 0 0", err_ovf, err_unf); end
    step();
    n_checks++; if (ready_to_rd !== 1'b1) begin n_fail++; $display("FAIL simul_ready: got %b want 1", ready_to_rd); end
    // 4481 + 383 = 4864 keeps ready high; one more pixel drops it
    stream_grey(383);
    repeat (2) step();
    n_checks++; if (ready_to_rd !== 1'b1) begin n_fail++; $display("FAIL simul_occ_4864: got %b want 1", ready_to_rd); end
    stream_grey(1);
    repeat (2) step();
    n_checks++; if (ready_to_rd !== 1'b0) begin n_fail++; $display("FAIL simul_occ_4865: got %b want 0", ready_to_rd); end
  endtask

  task automatic test_underflow();
    do_reset();
    row_ack = 1'b1;
    step();
    row_ack = 1'b0;
    n_checks++; if (err_unf !== 1'b1 || err_ovf !== 1'b0) begin n_fail++; $display("FAIL unf_set: got unf %b ovf %b want 1 0", err_unf, err_ovf); end
    repeat (2) step();
    n_checks++; if (err_unf !== 1'b1 || ready_to_rd !== 1'b1) begin n_fail++; $display("FAIL unf_sticky: got unf %b ready %b want 1 1", err_unf, ready_to_rd); end
  endtask

  task automatic test_frame();
    int nfd = 0, nwr = 0, bad = 0, misal = 0, post_fd = 0;
    logic [31:0] fd_addr = '1;
    logic [31:0] post_addr = '1;
    do_reset();
    for (int i = 0; i < NPIX + 6; i++) begin
      if (i < NPIX) begin
        px_valid = 1'b1; fmt_grey = 1'b1; px_data = 16'hC35A;
        row_ack = (i >= 2560) && (i % IMG_W == 0);
      end else idle_in();
      step();
      if (bram_wr_en === 1'b1) begin
        nwr++;
        if (bram_data !== 32'h0000_5A5A) bad++;
      end
      if (frame_done === 1'b1) begin
        nfd++;
        fd_addr = bram_addr;
        if (bram_wr_en !== 1'b1) misal++;
      end
    end
    n_checks++; if (nfd != 1) begin n_fail++; $display("FAIL frame_done_count: got %0d want 1", nfd); end
    n_checks++; if (misal != 0 || fd_addr !== 32'd2559) begin n_fail++; $display("FAIL frame_done_align: got misaligned %0d addr %0d want 0 2559", misal, fd_addr); end
    n_checks++; if (nwr != NPIX / 2 || bad != 0) begin n_fail++; $display("FAIL frame_words: got %0d writes %0d bad want %0d 0", nwr, bad, NPIX / 2); end
    n_checks++; if (err_ovf !== 1'b0 || err_unf !== 1'b0) begin n_fail++; $display("FAIL frame_errs: got ovf %b unf %b want 0 0", err_ovf, err_unf); end
    stream_grey(2);
    for (int i = 0; i < 4; i++) begin
      step();
      if (bram_wr_en === 1'b1) post_addr = bram_addr;
      if (frame_done === 1'b1) post_fd++;
    end
    n_checks++; if (post_addr !== 32'd0 || post_fd != 0) begin n_fail++; $display("FAIL frame_next: got addr %0d fd %0d want 0 0", post_addr, post_fd); end
  endtask

  initial begin
    test_reset();
    test_luma();
    test_fill();
    test_wrap();
    test_simul();
    test_underflow();
    test_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
